// File: rtl/minsoc_rst_seq.sv
// rtl/minsoc_rst_seq.sv - SoC reset sequencer: lock stretch, button debounce, reset cause
// Optional watchdog reset enabled by defining RST_SEQ_WDT_EN.
module minsoc_rst_seq #(
    parameter int unsigned STRETCH_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int unsigned WDT_CYCLES      = 65535,
    parameter int unsigned WDT_W           = 16
`endif
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       dcm_locked_i,
    input  logic       ext_rst_i,
`ifdef RST_SEQ_WDT_EN
    input  logic       wdt_kick_i,
`endif
    output logic       rst_o,
    output logic       rst_n_o,
    output logic       ready_o,
    output logic [1:0] rst_cause_o
);

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STRETCH   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;
`ifdef RST_SEQ_WDT_EN
    localparam logic [1:0] CAUSE_WDT  = 2'b11;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
`endif

    // Debounce counter carries one extra bit so DEBOUNCE_CYCLES may equal 2^CNT_W.
    localparam logic [CNT_W:0]   DEB_MAX      = (CNT_W + 1)'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

    logic             lock_meta;
    logic             lock_s;
    logic             btn_meta;
    logic             btn_s;
    logic [CNT_W:0]   btn_cnt_q;
    logic             btn_req;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stretch_q;
    logic [CNT_W-1:0] stretch_d;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    logic             rst_q;
`ifdef RST_SEQ_WDT_EN
    logic [WDT_W-1:0] wdt_q;
    logic [WDT_W-1:0] wdt_d;
`endif

    assign btn_req = (btn_cnt_q == DEB_MAX);

    always_comb begin
        state_d   = state_q;
        stretch_d = '0;
        cause_d   = cause_q;
`ifdef RST_SEQ_WDT_EN
        wdt_d     = '0;
`endif
        case (state_q)
            ST_ASSERT: begin
                if (!btn_req) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s && !btn_req) begin
                    state_d = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                // Any abort leaves stretch_d at its cleared default.
                if (btn_req) begin
                    state_d = ST_ASSERT;
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stretch_q == STRETCH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    stretch_d = stretch_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (btn_req) begin
                    state_d = ST_ASSERT;
                    cause_d = CAUSE_BTN;
                end else if (!lock_s) begin
                    state_d = ST_ASSERT;
                    cause_d = CAUSE_LOCK;
`ifdef RST_SEQ_WDT_EN
                end else if (wdt_kick_i) begin
                    wdt_d = '0;
                end else if (wdt_q == WDT_LAST) begin
                    state_d = ST_ASSERT;
                    cause_d = CAUSE_WDT;
                end else begin
                    wdt_d = wdt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            btn_cnt_q <= '0;
            state_q   <= ST_ASSERT;
            stretch_q <= '0;
            cause_q   <= CAUSE_POR;
            rst_q     <= 1'b1;
`ifdef RST_SEQ_WDT_EN
            wdt_q     <= '0;
`endif
        end else begin
            lock_meta <= dcm_locked_i;
            lock_s    <= lock_meta;
            btn_meta  <= ext_rst_i;
            btn_s     <= btn_meta;
            if (!btn_s) begin
                btn_cnt_q <= '0;
            end else if (btn_cnt_q != DEB_MAX) begin
                btn_cnt_q <= btn_cnt_q + 1'b1;
            end
            state_q   <= state_d;
            stretch_q <= stretch_d;
            cause_q   <= cause_d;
            // Registered from next state so reset moves on the same edge as the FSM.
            rst_q     <= (state_d != ST_RUN);
`ifdef RST_SEQ_WDT_EN
            wdt_q     <= wdt_d;
`endif
        end
    end

    assign rst_o       = rst_q;
    assign rst_n_o     = ~rst_q;
    assign ready_o     = ~rst_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_minsoc_rst_seq.sv
// tb/tb_minsoc_rst_seq.sv - directed bench for minsoc_rst_seq (watchdog tests under RST_SEQ_WDT_EN)
module tb_minsoc_rst_seq;

    logic       clk_i;
    logic       rst_n_i;
    logic       dcm_locked_i;
    logic       ext_rst_i;
`ifdef RST_SEQ_WDT_EN
    logic       wdt_kick_i;
`endif
    logic       rst_o;
    logic       rst_n_o;
    logic       ready_o;
    logic [1:0] rst_cause_o;

    int total;
    int bad;

    minsoc_rst_seq #(
        .STRETCH_CYCLES (16),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
`ifdef RST_SEQ_WDT_EN
        ,
        .WDT_CYCLES     (100),
        .WDT_W          (16)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .dcm_locked_i(dcm_locked_i),
        .ext_rst_i   (ext_rst_i),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick_i  (wdt_kick_i),
`endif
        .rst_o       (rst_o),
        .rst_n_o     (rst_n_o),
        .ready_o     (ready_o),
        .rst_cause_o (rst_cause_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        dcm_locked_i = 1'b1;
        ext_rst_i = 1'b0;
        step(5);
        total++;
        if (rst_o !== 1'b1 || rst_n_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs rst_o=%b rst_n_o=%b ready_o=%b want 1/0/0", rst_o, rst_n_o, ready_o);
        end
        total++;
        if (rst_cause_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_cause got=%b want=00", rst_cause_o);
        end
        rst_n_i = 1'b1;
        step(18);
        total++;
        if (rst_o !== 1'b1) begin
            bad++;
            $display("FAIL por_hold_18 rst_o=%b want 1", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b0 || rst_n_o !== 1'b1 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL por_release_19 rst_o=%b rst_n_o=%b ready_o=%b want 0/1/1", rst_o, rst_n_o, ready_o);
        end
        total++;
        if (rst_cause_o !== 2'b00) begin
            bad++;
            $display("FAIL por_cause got=%b want=00", rst_cause_o);
        end
    endtask

    task automatic test_lock_glitch();
        rst_n_i = 1'b0;
        dcm_locked_i = 1'b0;
        step(3);
        rst_n_i = 1'b1;
        step(5);
        dcm_locked_i = 1'b1;
        step(13);
        dcm_locked_i = 1'b0;
        step(3);
        dcm_locked_i = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1);
            total++;
            if (rst_o !== 1'b1) begin
                bad++;
                $display("FAIL glitch_hold edge=%0d rst_o=%b want 1", i, rst_o);
            end
        end
        step(1);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL glitch_release rst_o=%b want 0", rst_o);
        end
        total++;
        if (rst_cause_o !== 2'b00) begin
            bad++;
            $display("FAIL glitch_cause got=%b want=00", rst_cause_o);
        end
    endtask

    task automatic test_button();
        ext_rst_i = 1'b1;
        step(3);
        ext_rst_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            total++;
            if (rst_o !== 1'b0) begin
                bad++;
                $display("FAIL short_pulse cycle=%0d rst_o=%b want 0", i, rst_o);
            end
        end
        ext_rst_i = 1'b1;
        step(6);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL press_pre_assert rst_o=%b want 0", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b1 || rst_cause_o !== 2'b10) begin
            bad++;
            $display("FAIL press_assert rst_o=%b cause=%b want 1/10", rst_o, rst_cause_o);
        end
        step(3);
        ext_rst_i = 1'b0;
        step(20);
        total++;
        if (rst_o !== 1'b1) begin
            bad++;
            $display("FAIL press_hold rst_o=%b want 1", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b0 || rst_cause_o !== 2'b10) begin
            bad++;
            $display("FAIL press_release rst_o=%b cause=%b want 0/10", rst_o, rst_cause_o);
        end
    endtask

    task automatic test_lock_loss();
        dcm_locked_i = 1'b0;
        step(2);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL lockloss_early rst_o=%b want 0", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b1 || rst_cause_o !== 2'b01) begin
            bad++;
            $display("FAIL lockloss_assert rst_o=%b cause=%b want 1/01", rst_o, rst_cause_o);
        end
        step(3);
        dcm_locked_i = 1'b1;
        step(18);
        total++;
        if (rst_o !== 1'b1) begin
            bad++;
            $display("FAIL relock_hold rst_o=%b want 1", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b0 || rst_cause_o !== 2'b01) begin
            bad++;
            $display("FAIL relock_release rst_o=%b cause=%b want 0/01", rst_o, rst_cause_o);
        end
    endtask

    task automatic test_simultaneous_and_async();
        ext_rst_i = 1'b1;
        step(4);
        dcm_locked_i = 1'b0;
        step(2);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL simul_early rst_o=%b want 0", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b1 || rst_cause_o !== 2'b10) begin
            bad++;
            $display("FAIL simul_cause rst_o=%b cause=%b want 1/10", rst_o, rst_cause_o);
        end
        ext_rst_i = 1'b0;
        dcm_locked_i = 1'b1;
        step(10);
        #2;
        rst_n_i = 1'b0;
        #1;
        total++;
        if (rst_o !== 1'b1 || ready_o !== 1'b0 || rst_cause_o !== 2'b00) begin
            bad++;
            $display("FAIL async_reset rst_o=%b ready_o=%b cause=%b want 1/0/00", rst_o, ready_o, rst_cause_o);
        end
        step(2);
        rst_n_i = 1'b1;
        step(18);
        total++;
        if (rst_o !== 1'b1) begin
            bad++;
            $display("FAIL async_restart_hold rst_o=%b want 1", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b0 || rst_cause_o !== 2'b00) begin
            bad++;
            $display("FAIL async_restart_release rst_o=%b cause=%b want 0/00", rst_o, rst_cause_o);
        end
    endtask

`ifdef RST_SEQ_WDT_EN
    task automatic test_watchdog();
        for (int i = 0; i < 20; i++) begin
            step(49);
            wdt_kick_i = 1'b1;
            step(1);
            wdt_kick_i = 1'b0;
            total++;
            if (rst_o !== 1'b0) begin
                bad++;
                $display("FAIL wdt_kicked iter=%0d rst_o=%b want 0", i, rst_o);
            end
        end
        step(99);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL wdt_pre_timeout rst_o=%b want 0", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b1 || rst_cause_o !== 2'b11) begin
            bad++;
            $display("FAIL wdt_timeout rst_o=%b cause=%b want 1/11", rst_o, rst_cause_o);
        end
        step(18);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL wdt_rerun rst_o=%b want 0", rst_o);
        end
        step(99);
        wdt_kick_i = 1'b1;
        step(1);
        wdt_kick_i = 1'b0;
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL wdt_kick_at_timeout rst_o=%b want 0", rst_o);
        end
        step(99);
        total++;
        if (rst_o !== 1'b0) begin
            bad++;
            $display("FAIL wdt_post_kick_hold rst_o=%b want 0", rst_o);
        end
        step(1);
        total++;
        if (rst_o !== 1'b1 || rst_cause_o !== 2'b11) begin
            bad++;
            $display("FAIL wdt_second_timeout rst_o=%b cause=%b want 1/11", rst_o, rst_cause_o);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst_n_i = 1'b0;
        dcm_locked_i = 1'b0;
        ext_rst_i = 1'b0;
`ifdef RST_SEQ_WDT_EN
        wdt_kick_i = 1'b0;
`endif
        test_reset();
        test_lock_glitch();
        test_button();
        test_lock_loss();
        test_simultaneous_and_async();
`ifdef RST_SEQ_WDT_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
